llc_input_arbiter: RTL

- Schedules which LLC input channel the core's DECODE stage consumes next: coherence response, reset/flush, CPU request or DMA request.
- Sits between the four input FIFOs and the LLC core decode logic. Drives the per-channel ready signals and holds the active channel until the core signals transaction completion.
- Enforces the blocking rules for stall, flush and recall, and applies bounded fairness between CPU requests and DMA requests.

---
 rtl/llc_input_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/llc_input_arbiter.sv
// llc_input_arbiter: picks the next LLC input channel for DECODE and holds it until txn_done; optional LLC_ARB_STATS_EN grant counters.
module llc_input_arbiter #(
  parameter int MAX_CONSEC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       decode_en,
  input  logic       txn_done,
  input  logic       rsp_valid,
  input  logic       rst_tb_valid,
  input  logic       req_valid,
  input  logic       dma_req_valid,
  input  logic       req_stall,
  input  logic       flush_stall,
  input  logic       rst_stall,
  input  logic       recall_pending,
  output logic       rsp_ready,
  output logic       rst_tb_ready,
  output logic       req_ready,
  output logic       dma_req_ready,
  output logic [2:0] grant,
  output logic       busy
`ifdef LLC_ARB_STATS_EN
  ,
  output logic [15:0] stat_rsp_cnt,
  output logic [15:0] stat_rst_cnt,
  output logic [15:0] stat_req_cnt,
  output logic [15:0] stat_dma_cnt,
  output logic [15:0] stat_starve_cnt
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] MAX = 4'(MAX_CONSEC);
  state_t state;
  logic [3:0] cnt;
  logic e_rsp, e_rst, e_req, e_dma, go, force_dma;
  logic [2:0] code;
  always_comb begin
    e_rsp = rsp_valid;
    e_rst = rst_tb_valid && !flush_stall && !rst_stall;
    e_req = req_valid && !req_stall && !flush_stall;
    e_dma = dma_req_valid && !flush_stall && !recall_pending;
    go = state == IDLE && decode_en && !rst;
    force_dma = e_dma && e_req && cnt == MAX;
    rsp_ready = go && e_rsp;
    rst_tb_ready = go && !e_rsp && e_rst;
    req_ready = go && !e_rsp && !e_rst && e_req && !force_dma;
    dma_req_ready = go && !e_rsp && !e_rst && e_dma && (!e_req || force_dma);
    code = rsp_ready ? 3'd1 : rst_tb_ready ? 3'd2 : req_ready ? 3'd3 : dma_req_ready ? 3'd4 : 3'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      grant <= 3'd0;
      cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (code != 3'd0) begin
        state <= BUSY;
        busy <= 1'b1;
        grant <= code;
      end
      if (dma_req_ready) cnt <= 4'd0;
      else if (req_ready && e_dma && cnt != MAX) cnt <= cnt + 4'd1;
    end else if (txn_done) begin
      state <= IDLE;
      busy <= 1'b0;
      grant <= 3'd0;
    end
  end
`ifdef LLC_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rsp_cnt <= '0;
      stat_rst_cnt <= '0;
      stat_req_cnt <= '0;
      stat_dma_cnt <= '0;
      stat_starve_cnt <= '0;
    end else begin
      if (rsp_ready && stat_rsp_cnt != 16'hFFFF) stat_rsp_cnt <= stat_rsp_cnt + 16'd1;
      if (rst_tb_ready && stat_rst_cnt != 16'hFFFF) stat_rst_cnt <= stat_rst_cnt + 16'd1;
      if (req_ready && stat_req_cnt != 16'hFFFF) stat_req_cnt <= stat_req_cnt + 16'd1;
      if (dma_req_ready && stat_dma_cnt != 16'hFFFF) stat_dma_cnt <= stat_dma_cnt + 16'd1;
      if (dma_req_ready && force_dma && stat_starve_cnt != 16'hFFFF) stat_starve_cnt <= stat_starve_cnt + 16'd1;
    end
  end
`endif
endmodule
